// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants, the coordinate type and the
// derived sync-window boundaries shared by the VGA timing generator.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [9:0] coord_t;

    // Sync windows are half-open: [START, END)
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

endpackage

// File: rtl/vga_pix_div.sv
// vga_pix_div: clock-enable divider producing the pixel strobe.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset (div returns to 0)
//   pix_en - high on the clk where div == CLK_DIV-1, never during reset
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);

    // Keep at least one bit so CLK_DIV=1 still has a (constant-zero) register.
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign pix_en = (div_reg == DIV_LAST) && !reset;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster scan generator for a VGA monitor (default 640x480@60).
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   pix_en       - one-clk pixel strobe; hc/vc advance on it
//   DrawX, DrawY - current column / line, not clamped in blanking
//   hs, vs       - sync strobes, level SYNC_ACTIVE while asserted
//   display_en   - high inside the visible region
//   line_start   - pulse on the clk whose edge wraps hc to 0
//   frame_start  - pulse on the clk whose edge wraps both hc and vc to 0
//   frame_cnt    - (only with VGA_FRAME_CNT_EN) frames started since reset
// Optional feature macro: VGA_FRAME_CNT_EN
import vga_pkg::*;

module vga_timing_gen #(
    parameter int   H_VISIBLE   = vga_pkg::H_VISIBLE,
    parameter int   H_FP        = vga_pkg::H_FP,
    parameter int   H_SYNC      = vga_pkg::H_SYNC,
    parameter int   H_BP        = vga_pkg::H_BP,
    parameter int   V_VISIBLE   = vga_pkg::V_VISIBLE,
    parameter int   V_FP        = vga_pkg::V_FP,
    parameter int   V_SYNC      = vga_pkg::V_SYNC,
    parameter int   V_BP        = vga_pkg::V_BP,
    parameter int   CLK_DIV     = 2,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        pix_en,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        hs,
    output logic        vs,
    output logic        display_en,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_BEG_C = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END_C = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_BEG_C = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END_C = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t hc_reg;
    coord_t vc_reg;
    logic   line_end;
    logic   frame_end;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en)
    );

    assign line_end  = (hc_reg == H_LAST);
    assign frame_end = (vc_reg == V_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            hc_reg <= '0;
            vc_reg <= '0;
        end else if (pix_en) begin
            if (line_end) begin
                hc_reg <= '0;
                vc_reg <= frame_end ? coord_t'(0) : vc_reg + 1'b1;
            end else begin
                hc_reg <= hc_reg + 1'b1;
            end
        end
    end

    // All decodes come straight from the counter registers so they share
    // the same timing and never skew against each other.
    assign DrawX       = hc_reg;
    assign DrawY       = vc_reg;
    assign hs          = (hc_reg >= HS_BEG_C && hc_reg < HS_END_C) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vs          = (vc_reg >= VS_BEG_C && vc_reg < VS_END_C) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign display_en  = (hc_reg < H_VIS_C) && (vc_reg < V_VIS_C);
    // pix_en already carries !reset, so no pulse escapes during reset.
    assign line_start  = pix_en && line_end;
    assign frame_start = line_start && frame_end;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_reg <= '0;
        end else if (frame_start) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen. Three instances
// share one clock: default timing (CLK_DIV=2), a small raster with CLK_DIV=3
// and active-high sync, and a small raster with CLK_DIV=1. Expected outputs
// come from an arithmetic model of clocks elapsed since reset release.
import vga_pkg::*;

module tb_vga_timing_gen;

    // Instance B timing
    localparam int BHV = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVV = 6, BVF = 1, BVS = 2, BVB = 2;
    localparam int BD = 3;
    localparam logic BACT = 1'b1;
    // Instance C timing
    localparam int CHV = 10, CHF = 1, CHS = 2, CHB = 3;
    localparam int CVV = 5, CVF = 2, CVS = 1, CVB = 1;
    localparam int CD = 1;
    localparam logic CACT = 1'b0;

    localparam int B_FRAME = (BHV+BHF+BHS+BHB) * (BVV+BVF+BVS+BVB);
    localparam int C_FRAME = (CHV+CHF+CHS+CHB) * (CVV+CVF+CVS+CVB);

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

    logic       pe_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       pe_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;
    logic       pe_c, hs_c, vs_c, de_c, ls_c, fs_c;
    logic [9:0] x_c, y_c;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b, fc_c;
`endif

    int vectors = 0;
    int miscompares = 0;
    int k_a = 0, k_b = 0, k_c = 0;   // clk edges since reset was last sampled high

    always #5 clk = ~clk;

    always @(posedge clk) begin
        k_a <= rst_a ? 0 : k_a + 1;
        k_b <= rst_b ? 0 : k_b + 1;
        k_c <= rst_c ? 0 : k_c + 1;
    end

    vga_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .pix_en(pe_a), .DrawX(x_a), .DrawY(y_a),
        .hs(hs_a), .vs(vs_a), .display_en(de_a), .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_VISIBLE(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .CLK_DIV(BD), .SYNC_ACTIVE(BACT)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pix_en(pe_b), .DrawX(x_b), .DrawY(y_b),
        .hs(hs_b), .vs(vs_b), .display_en(de_b), .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    vga_timing_gen #(
        .H_VISIBLE(CHV), .H_FP(CHF), .H_SYNC(CHS), .H_BP(CHB),
        .V_VISIBLE(CVV), .V_FP(CVF), .V_SYNC(CVS), .V_BP(CVB),
        .CLK_DIV(CD), .SYNC_ACTIVE(CACT)
    ) dut_c (
        .clk(clk), .reset(rst_c), .pix_en(pe_c), .DrawX(x_c), .DrawY(y_c),
        .hs(hs_c), .vs(vs_c), .display_en(de_c), .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_c)
`endif
    );

    // Reference: with k edges since release, floor(k/d) pixel strobes have
    // been consumed; position follows from division by the line/frame sizes.
    // Packed as {pix_en, x[9:0], y[9:0], hs, vs, display_en, line_start, frame_start}.
    function automatic logic [25:0] model(int k, logic rst, int d,
                                          int hv, int hf, int hsy, int hb,
                                          int vv, int vf, int vsy, int vb, logic act);
        int ht = hv + hf + hsy + hb;
        int vt = vv + vf + vsy + vb;
        int p  = k / d;
        int x  = p % ht;
        int y  = (p / ht) % vt;
        logic pe = !rst && ((k % d) == d - 1);
        logic ls = pe && (x == ht - 1);
        logic fs = ls && (y == vt - 1);
        logic h  = (x >= hv + hf && x < hv + hf + hsy) ? act : ~act;
        logic v  = (y >= vv + vf && y < vv + vf + vsy) ? act : ~act;
        logic de = (x < hv) && (y < vv);
        return {pe, 10'(x), 10'(y), h, v, de, ls, fs};
    endfunction

    function automatic logic [25:0] exp_a();
        return model(k_a, rst_a, 2, H_VISIBLE, H_FP, H_SYNC, H_BP,
                     V_VISIBLE, V_FP, V_SYNC, V_BP, 1'b0);
    endfunction
    function automatic logic [25:0] exp_b();
        return model(k_b, rst_b, BD, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, BACT);
    endfunction
    function automatic logic [25:0] exp_c();
        return model(k_c, rst_c, CD, CHV, CHF, CHS, CHB, CVV, CVF, CVS, CVB, CACT);
    endfunction

    function automatic logic [25:0] obs_a();
        return {pe_a, x_a, y_a, hs_a, vs_a, de_a, ls_a, fs_a};
    endfunction
    function automatic logic [25:0] obs_b();
        return {pe_b, x_b, y_b, hs_b, vs_b, de_b, ls_b, fs_b};
    endfunction
    function automatic logic [25:0] obs_c();
        return {pe_c, x_c, y_c, hs_c, vs_c, de_c, ls_c, fs_c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [25:0] want;
        rst_a = 1'b1;
        want = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs_a() !== want) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs_a(), want);
            end
        end
`ifdef VGA_FRAME_CNT_EN
        vectors++;
        if (fc_a !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_frame_cnt got=%0d want=0", fc_a);
        end
`endif
        rst_a = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (i == 1 && pe_a !== 1'b1) begin
                miscompares++;
                $display("FAIL release_pix_en got=%b want=1", pe_a);
            end
            vectors++;
            if (i == 2 && (x_a !== 10'd1 || pe_a !== 1'b0)) begin
                miscompares++;
                $display("FAIL release_drawx got x=%0d pe=%b want x=1 pe=0", x_a, pe_a);
            end
            vectors++;
            if (obs_a() !== exp_a()) begin
                miscompares++;
                $display("FAIL release_model cyc=%0d got=%h want=%h", i, obs_a(), exp_a());
            end
        end
    endtask

    task automatic test_line_timing();
        int   hs_low = 0;
        int   ls_cnt = 0;
        logic prev_de;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        prev_de = de_a;
        for (int i = 0; i < 3 * 1600 + 4; i++) begin
            tick();
            vectors++;
            if (obs_a() !== exp_a()) begin
                miscompares++;
                $display("FAIL line_model k=%0d got=%h want=%h", k_a, obs_a(), exp_a());
            end
            if (y_a == 10'd0 && hs_a == 1'b0) hs_low++;
            if (ls_a) ls_cnt++;
            if (prev_de && !de_a) begin
                vectors++;
                if (x_a !== 10'd640) begin
                    miscompares++;
                    $display("FAIL de_fall got x=%0d want 640", x_a);
                end
            end
            prev_de = de_a;
        end
        vectors++;
        if (hs_low != 192) begin
            miscompares++;
            $display("FAIL hs_width got=%0d clks want=192", hs_low);
        end
        vectors++;
        if (ls_cnt != 3) begin
            miscompares++;
            $display("FAIL line_start_count got=%0d want=3", ls_cnt);
        end
    endtask

    task automatic test_frame_timing();
        int vs_act = 0;
        int fs_seen = 0;
        int last_k = -1;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        for (int i = 0; i < 3 * B_FRAME * BD + 5; i++) begin
            tick();
            vectors++;
            if (obs_b() !== exp_b()) begin
                miscompares++;
                $display("FAIL frame_model k=%0d got=%h want=%h", k_b, obs_b(), exp_b());
            end
            if (fs_seen == 0 && vs_b == BACT) vs_act++;
            vectors++;
            if (y_b >= 10'(BVV) && de_b !== 1'b0) begin
                miscompares++;
                $display("FAIL de_vblank y=%0d got=%b want=0", y_b, de_b);
            end
            if (fs_b) begin
                if (last_k >= 0) begin
                    vectors++;
                    if (k_b - last_k != B_FRAME * BD) begin
                        miscompares++;
                        $display("FAIL frame_period got=%0d want=%0d", k_b - last_k, B_FRAME * BD);
                    end
                end
                last_k = k_b;
                fs_seen++;
            end
        end
        vectors++;
        if (vs_act != BVS * (BHV+BHF+BHS+BHB) * BD || fs_seen != 3) begin
            miscompares++;
            $display("FAIL vs_width got=%0d frames=%0d want=%0d frames=3",
                     vs_act, fs_seen, BVS * (BHV+BHF+BHS+BHB) * BD);
        end
    endtask

    task automatic test_mid_frame_reset();
        bit found = 0;
        for (int i = 0; i < 2 * B_FRAME * BD && !found; i++) begin
            tick();
            if (x_b == 10'd5 && y_b == 10'd4) found = 1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL midreset_reach got x=%0d y=%0d want x=5 y=4", x_b, y_b);
        end
        rst_b = 1'b1;
        tick();
        vectors++;
        if (x_b !== 10'd0 || y_b !== 10'd0 || fs_b !== 1'b0 || pe_b !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state got x=%0d y=%0d fs=%b pe=%b want 0 0 0 0",
                     x_b, y_b, fs_b, pe_b);
        end
`ifdef VGA_FRAME_CNT_EN
        vectors++;
        if (fc_b !== 16'd0) begin
            miscompares++;
            $display("FAIL midreset_frame_cnt got=%0d want=0", fc_b);
        end
`endif
        rst_b = 1'b0;
        for (int i = 0; i < 2 * BD + 2; i++) begin
            tick();
            vectors++;
            if (obs_b() !== exp_b()) begin
                miscompares++;
                $display("FAIL midreset_model k=%0d got=%h want=%h", k_b, obs_b(), exp_b());
            end
        end
    endtask

    task automatic test_clk_div1();
        int last_k = -1;
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        #1;
        for (int i = 0; i < 3 * C_FRAME + 3; i++) begin
            vectors++;
            if (pe_c !== 1'b1 || obs_c() !== exp_c()) begin
                miscompares++;
                $display("FAIL div1_model k=%0d got=%h want=%h", k_c, obs_c(), exp_c());
            end
            if (fs_c) begin
                if (last_k >= 0) begin
                    vectors++;
                    if (k_c - last_k != C_FRAME) begin
                        miscompares++;
                        $display("FAIL div1_period got=%0d want=%0d", k_c - last_k, C_FRAME);
                    end
                end
                last_k = k_c;
            end
            tick();
        end
    endtask

    task automatic test_random_reset();
        int len;
        int sel;
        for (int it = 0; it < 40; it++) begin
            len = $urandom_range(1, 300);
            for (int i = 0; i < len; i++) begin
                tick();
                vectors++;
                if (obs_a() !== exp_a() || obs_b() !== exp_b() || obs_c() !== exp_c()) begin
                    miscompares++;
                    $display("FAIL random it=%0d a=%h/%h b=%h/%h c=%h/%h", it,
                             obs_a(), exp_a(), obs_b(), exp_b(), obs_c(), exp_c());
                end
            end
            sel = $urandom_range(0, 2);
            len = $urandom_range(1, 3);
            if (sel == 0) rst_a = 1'b1;
            if (sel == 1) rst_b = 1'b1;
            if (sel == 2) rst_c = 1'b1;
            for (int i = 0; i < len; i++) begin
                tick();
                vectors++;
                if (obs_a() !== exp_a() || obs_b() !== exp_b() || obs_c() !== exp_c()) begin
                    miscompares++;
                    $display("FAIL random_rst it=%0d a=%h/%h b=%h/%h c=%h/%h", it,
                             obs_a(), exp_a(), obs_b(), exp_b(), obs_c(), exp_c());
                end
            end
            rst_a = 1'b0;
            rst_b = 1'b0;
            rst_c = 1'b0;
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int fs_seen = 0;
        bit seen = 0;
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        for (int i = 0; i < 4 * C_FRAME && fs_seen < 3; i++) begin
            tick();
            if (fs_c) fs_seen++;
        end
        tick();
        vectors++;
        if (fc_c !== 16'd3) begin
            miscompares++;
            $display("FAIL frame_cnt_three got=%0d want=3", fc_c);
        end
        force dut_c.frame_cnt_reg = 16'hFFFF;
        tick();
        release dut_c.frame_cnt_reg;
        for (int i = 0; i < 2 * C_FRAME && !seen; i++) begin
            tick();
            if (fs_c) seen = 1;
        end
        tick();
        vectors++;
        if (!seen || fc_c !== 16'd0) begin
            miscompares++;
            $display("FAIL frame_cnt_wrap got=%0d seen=%0d want=0", fc_c, seen);
        end
    endtask
`endif

    initial begin
        rst_b = 1'b1;
        rst_c = 1'b1;
        test_reset();
        test_line_timing();
        rst_b = 1'b0;
        test_frame_timing();
        test_mid_frame_reset();
        test_clk_div1();
        test_random_reset();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
